// File: rtl/pipeline_dmem_responder.sv
// Data-memory responder for the pipelined CPU: a word RAM and an MMIO block with GPIO, a cycle counter, a timer and status.
// Optional misaligned-access trapping is enabled by defining DMEM_MISALIGN_CHECK_EN.
`timescale 1ns/1ps

module pipeline_dmem_responder #(
   parameter int          ADDR_WIDTH = 10,
   parameter logic [31:0] MMIO_BASE  = 32'hF000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRW_Mem,
   input  logic [31:0] Addr_out,
   input  logic [31:0] Data_out,
   output logic [31:0] Data_in,
   input  logic [15:0] gpio_in,
   output logic [15:0] gpio_out,
   output logic        timer_irq
);

   localparam logic [5:0] OFS_GPIO_OUT  = 6'h00;
   localparam logic [5:0] OFS_GPIO_IN   = 6'h01;
   localparam logic [5:0] OFS_CYCLE     = 6'h02;
   localparam logic [5:0] OFS_TIMER_CMP = 6'h03;
   localparam logic [5:0] OFS_STATUS    = 6'h04;

   logic [31:0] mem [2**ADDR_WIDTH];

   logic [15:0] gpio_out_reg;
   logic [15:0] gpio_sync0_reg;
   logic [15:0] gpio_sync1_reg;
   logic [31:0] cycle_reg;
   logic [31:0] timer_cmp_reg;
   logic [1:0]  status_reg;
   logic [1:0]  status_next;
   logic [1:0]  status_set;
   logic [1:0]  status_clr;

   logic                  mmio_sel;
   logic                  misalign;
   logic                  wr_ok;
   logic                  mmio_wr;
   logic [5:0]            mmio_ofs;
   logic [ADDR_WIDTH-1:0] ram_idx;
   logic                  unused_addr_bits;

   assign mmio_sel = (Addr_out[31:28] == MMIO_BASE[31:28]);
   assign ram_idx  = Addr_out[ADDR_WIDTH+1:2];
   // MMIO registers are word-decoded, so the byte offset bits never change which register is hit.
   assign mmio_ofs = Addr_out[7:2];

`ifdef DMEM_MISALIGN_CHECK_EN
   assign misalign = (Addr_out[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign wr_ok   = MemRW_Mem && !misalign;
   assign mmio_wr = wr_ok && mmio_sel;

   assign unused_addr_bits = ^{1'b0, Addr_out};

   // RAM has no reset, so it keeps writing even while rst is asserted.
   always_ff @(posedge clk) begin
      if (wr_ok && !mmio_sel) begin
         mem[ram_idx] <= Data_out;
      end
   end

   assign status_set[0] = (cycle_reg == timer_cmp_reg);
   assign status_set[1] = misalign;
   assign status_clr    = (mmio_wr && mmio_ofs == OFS_STATUS) ? Data_out[1:0] : 2'b00;

   // A set in the same cycle as a write-1-to-clear keeps the bit high.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_status
         assign status_next[gi] = (status_reg[gi] & ~status_clr[gi]) | status_set[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         gpio_out_reg   <= 16'h0000;
         gpio_sync0_reg <= 16'h0000;
         gpio_sync1_reg <= 16'h0000;
         cycle_reg      <= 32'h0000_0000;
         timer_cmp_reg  <= 32'hFFFF_FFFF;
         status_reg     <= 2'b00;
      end else begin
         gpio_sync0_reg <= gpio_in;
         gpio_sync1_reg <= gpio_sync0_reg;
         cycle_reg      <= cycle_reg + 32'd1;
         status_reg     <= status_next;
         if (mmio_wr && mmio_ofs == OFS_GPIO_OUT) begin
            gpio_out_reg <= Data_out[15:0];
         end
         if (mmio_wr && mmio_ofs == OFS_TIMER_CMP) begin
            timer_cmp_reg <= Data_out;
         end
      end
   end

   always_comb begin
      Data_in = 32'h0000_0000;
      if (mmio_sel) begin
         case (mmio_ofs)
            OFS_GPIO_OUT:  Data_in = {16'h0000, gpio_out_reg};
            OFS_GPIO_IN:   Data_in = {16'h0000, gpio_sync1_reg};
            OFS_CYCLE:     Data_in = cycle_reg;
            OFS_TIMER_CMP: Data_in = timer_cmp_reg;
            OFS_STATUS:    Data_in = {30'h0, status_reg};
            default:       Data_in = 32'h0000_0000;
         endcase
      end else begin
         Data_in = mem[ram_idx];
      end
   end

   assign gpio_out  = gpio_out_reg;
   assign timer_irq = status_reg[0];

endmodule

// File: tb/tb_pipeline_dmem_responder.sv
// Scoreboard bench for pipeline_dmem_responder: expectations are queued as each cycle is driven and checked mid-cycle.
`timescale 1ns/1ps

module tb_pipeline_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        MemRW_Mem = 1'b0;
   logic [31:0] Addr_out = 32'h0;
   logic [31:0] Data_out = 32'h0;
   logic [31:0] Data_in;
   logic [15:0] gpio_in = 16'h0;
   logic [15:0] gpio_out;
   logic        timer_irq;

   localparam int K_RD   = 0;
   localparam int K_GPIO = 1;
   localparam int K_IRQ  = 2;

`ifdef DMEM_MISALIGN_CHECK_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   string       tag_q[$];
   int          kind_q[$];
   logic [31:0] exp_q[$];

   int          vectors     = 0;
   int          miscompares = 0;
   int unsigned cyc_m       = 0;
   logic        last_rst    = 1'b1;
   logic [31:0] cmp_v;

   pipeline_dmem_responder #(.ADDR_WIDTH(10), .MMIO_BASE(32'hF000_0000)) dut (
      .clk       (clk),
      .rst       (rst),
      .MemRW_Mem (MemRW_Mem),
      .Addr_out  (Addr_out),
      .Data_out  (Data_out),
      .Data_in   (Data_in),
      .gpio_in   (gpio_in),
      .gpio_out  (gpio_out),
      .timer_irq (timer_irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Start a cycle: wait for the falling edge, advance the cycle model, drive the access.
   task automatic cyc(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      cyc_m     = last_rst ? 0 : cyc_m + 1;
      last_rst  = r;
      rst       = r;
      MemRW_Mem = we;
      Addr_out  = a;
      Data_out  = d;
   endtask

   task automatic want(input string tag, input int kind, input logic [31:0] exp);
      tag_q.push_back(tag);
      kind_q.push_back(kind);
      exp_q.push_back(exp);
   endtask

   task automatic settle();
      logic [31:0] obs;
      int          k;
      #1;
      while (exp_q.size() > 0) begin
         k = kind_q.pop_front();
         if (k == K_RD)        obs = Data_in;
         else if (k == K_GPIO) obs = {16'h0, gpio_out};
         else                  obs = {31'h0, timer_irq};
         check(tag_q.pop_front(), obs, exp_q.pop_front());
      end
   endtask

   initial begin
      // Reset state
      cyc(1, 0, 32'h0, 32'h0); settle();
      cyc(0, 0, 32'hF000_0008, 0);
      want("cycle0", K_RD, 32'd0); want("rst_gpio", K_GPIO, 32'h0); want("rst_irq", K_IRQ, 32'h0); settle();
      cyc(0, 0, 32'hF000_0008, 0); want("cycle1", K_RD, 32'd1); settle();
      cyc(0, 0, 32'hF000_000C, 0); want("cmp_rst", K_RD, 32'hFFFF_FFFF); settle();
      cyc(0, 0, 32'hF000_0010, 0); want("status_rst", K_RD, 32'h0); settle();

      // RAM write/read and aliasing
      cyc(0, 1, 32'h0000_0010, 32'hDEAD_BEEF); settle();
      cyc(0, 0, 32'h0000_0010, 0); want("ram_rd", K_RD, 32'hDEAD_BEEF); settle();
      cyc(0, 0, 32'h0000_1010, 0); want("ram_alias", K_RD, 32'hDEAD_BEEF); settle();
      cyc(0, 1, 32'h0000_0014, 32'h1234_5678); settle();
      cyc(0, 0, 32'h0000_0014, 0); want("ram_rd2", K_RD, 32'h1234_5678); settle();
      cyc(0, 0, 32'h0000_0010, 0); want("ram_keep", K_RD, 32'hDEAD_BEEF); settle();

      // GPIO out and synchronised GPIO in
      cyc(0, 1, 32'hF000_0000, 32'h0001_A5A5); want("gpio_pre", K_GPIO, 32'h0); settle();
      cyc(0, 0, 32'hF000_0000, 0); want("gpio_rd", K_RD, 32'h0000_A5A5); want("gpio_pin", K_GPIO, 32'h0000_A5A5); settle();
      cyc(0, 0, 32'hF000_0004, 0); gpio_in = 16'h1234; want("gin_e0", K_RD, 32'h0); settle();
      cyc(0, 0, 32'hF000_0004, 0); want("gin_e1", K_RD, 32'h0); settle();
      cyc(0, 0, 32'hF000_0004, 0); want("gin_e2", K_RD, 32'h0000_1234); settle();

      // Unmapped offset and read-only CYCLE
      cyc(0, 1, 32'hF000_0020, 32'hFFFF_FFFF); settle();
      cyc(0, 0, 32'hF000_0020, 0); want("unmapped", K_RD, 32'h0); settle();
      cyc(0, 1, 32'hF000_0008, 32'h0); settle();
      cyc(0, 0, 32'hF000_0008, 0); want("cycle_ro", K_RD, cyc_m); settle();

      // Timer match
      cyc(0, 1, 32'hF000_000C, 0); cmp_v = cyc_m + 6; Data_out = cmp_v; settle();
      cyc(0, 0, 32'hF000_000C, 0); want("cmp_rd", K_RD, cmp_v); settle();
      do begin
         cyc(0, 0, 32'hF000_0010, 0);
         want("irq_rise", K_IRQ, {31'h0, (cyc_m > cmp_v)});
         want("stat_rise", K_RD, {31'h0, (cyc_m > cmp_v)});
         settle();
      end while (cyc_m < cmp_v + 2);
      cyc(0, 1, 32'hF000_0010, 32'h1); want("irq_hold", K_IRQ, 32'h1); settle();
      cyc(0, 0, 32'hF000_0010, 0); want("irq_clr", K_IRQ, 32'h0); want("stat_clr", K_RD, 32'h0); settle();

      // Clear and match on the same edge: set wins
      cyc(0, 1, 32'hF000_000C, 0); cmp_v = cyc_m + 2; Data_out = cmp_v; settle();
      cyc(0, 0, 32'hF000_0010, 0); want("sw_pre", K_IRQ, 32'h0); settle();
      cyc(0, 1, 32'hF000_0010, 32'h1); want("sw_at", K_IRQ, 32'h0); settle();
      cyc(0, 0, 32'hF000_0010, 0); want("set_wins", K_IRQ, 32'h1); want("sw_stat", K_RD, 32'h1); settle();
      cyc(0, 1, 32'hF000_0010, 32'h3); settle();
      cyc(0, 0, 32'hF000_0010, 0); want("stat_w1c", K_RD, 32'h0); settle();

      // Misaligned accesses
      cyc(0, 1, 32'h0000_0020, 32'h2222_2222); settle();
      cyc(0, 1, 32'h0000_0022, 32'h1111_1111); settle();
      cyc(0, 0, 32'h0000_0020, 0); want("mis_word", K_RD, MIS ? 32'h2222_2222 : 32'h1111_1111); settle();
      cyc(0, 0, 32'hF000_0010, 0); want("mis_stat", K_RD, MIS ? 32'h2 : 32'h0); settle();
      cyc(0, 0, 32'h0000_0023, 0); want("mis_rd", K_RD, MIS ? 32'h2222_2222 : 32'h1111_1111); settle();

      // Reset during an access
      while (cyc_m < 499) begin
         cyc(0, 0, 32'h0, 0); settle();
      end
      cyc(0, 0, 32'hF000_0008, 0); want("cycle500", K_RD, 32'd500); settle();
      cyc(1, 1, 32'hF000_0000, 32'h0000_00FF); want("rst_hold", K_GPIO, 32'h0000_A5A5); settle();
      cyc(1, 1, 32'h0000_0030, 32'hCAFE_F00D); settle();
      cyc(0, 0, 32'hF000_0008, 0);
      want("rst_cyc", K_RD, 32'd0); want("rst_gpio2", K_GPIO, 32'h0); want("rst_irq2", K_IRQ, 32'h0); settle();
      cyc(0, 0, 32'hF000_0010, 0); want("rst_stat", K_RD, 32'h0); settle();
      cyc(0, 0, 32'h0000_0030, 0); want("rst_ramwr", K_RD, 32'hCAFE_F00D); settle();
      cyc(0, 0, 32'hF000_000C, 0); want("rst_cmp", K_RD, 32'hFFFF_FFFF); settle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipeline_dmem_responder.md
Name: pipeline_dmem_responder

Overview:
Data-memory responder for the 5-stage pipeline CPU. It answers the CPU's MEM-stage access (address, store data, write strobe) and returns load data in the same cycle, so the MEM/WB register captures it at the next edge. It holds a word RAM plus a small MMIO window containing GPIO, a free-running cycle counter, a timer compare register and a status register. It sits outside the CPU top, connected to its Addr_out, Data_out, MemRW_Mem and Data_in ports.

Parameters:
ADDR_WIDTH, 10, word-address bits of RAM (2^ADDR_WIDTH 32-bit words).
MMIO_BASE, 32'hF000_0000, base of the MMIO window; decode uses addr[31:28] == MMIO_BASE[31:28].

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
MemRW_Mem  input  1  1 = write this cycle, 0 = read (reads are always implied).
Addr_out  input  32  byte address from the CPU MEM stage.
Data_out  input  32  store data from the CPU.
Data_in  output  32  load data to the CPU; combinational from Addr_out and current state.
gpio_in  input  16  asynchronous external inputs.
gpio_out  output  16  registered GPIO output.
timer_irq  output  1  equals STATUS[0].

Behaviour:
- Reset and clocking:
  - One clock, clk. rst is synchronous and active-high, sampled on the clk rising edge.
  - Reset values: gpio_out=0, CYCLE=0, TIMER_CMP=32'hFFFF_FFFF, STATUS=0, both gpio_in sync stages=0, timer_irq=0.
  - RAM contents are not reset.
  - Reset asserted mid-access: a write in the same cycle as rst is dropped for MMIO registers. RAM still writes, because RAM has no reset.
- Decode:
  - mmio_sel = (Addr_out[31:28] == MMIO_BASE[31:28]); otherwise the access targets RAM.
  - RAM index = Addr_out[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias.
- RAM:
  - Asynchronous read: Data_in = mem[index] in the same cycle (zero-latency).
  - Synchronous write on the clk edge when MemRW_Mem=1 and !mmio_sel.
  - Read of an address written in the previous cycle returns the new value.
- MMIO map, offset Addr_out[7:0]:
  - 0x00 GPIO_OUT (RW): only bits [15:0] are stored; reads zero-extend.
  - 0x04 GPIO_IN (RO): value of the 2-flop synchronizer. A gpio_in change is readable 2 edges later.
  - 0x08 CYCLE (RO): +1 every cycle, wraps 32'hFFFF_FFFF -> 0. Writes are ignored.
  - 0x0C TIMER_CMP (RW).
  - 0x10 STATUS:
    - bit0 = timer match, sticky; bit1 = misaligned access, sticky; other bits read 0.
    - Write-1-to-clear per bit.
  - Any other offset: reads 0, writes ignored.
- Reads have no side effects. The CPU has no read strobe, so every non-write cycle is treated as a read.
- Timer:
  - When CYCLE == TIMER_CMP (compared before the increment), STATUS[0] sets at that edge.
  - A W1C clear and a set in the same cycle: set wins.
- All MMIO register writes take effect at the edge and are visible to reads in the next cycle.

Optional Feature:
Macro DMEM_MISALIGN_CHECK_EN.
- Defined: an access with Addr_out[1:0] != 0 sets STATUS[1] (read or write). Its write is suppressed for both RAM and MMIO. A misaligned read still returns the word at the truncated index.
- Undefined: Addr_out[1:0] are ignored, writes proceed to the truncated word, and STATUS[1] always reads 0.

Test Plan:
- Reset then read 0xF000_0008 twice on consecutive cycles -> CYCLE 0 then 1; read 0xF000_000C -> 32'hFFFF_FFFF; timer_irq=0.
- Write 32'hDEAD_BEEF to 0x0000_0010, read 0x0000_0010 next cycle -> 32'hDEAD_BEEF; read alias 0x0000_1010 (ADDR_WIDTH=10) -> 32'hDEAD_BEEF.
- Write 32'h0001_A5A5 to 0xF000_0000 -> gpio_out=16'hA5A5 next cycle; reading it -> 32'h0000_A5A5. Drive gpio_in=16'h1234 -> read 0xF000_0004 returns 32'h0000_1234 only from the 2nd edge on.
- Write TIMER_CMP=20 at CYCLE<20 -> timer_irq rises after the edge where CYCLE==20. Write 1 to 0xF000_0010 -> irq clears. Set CMP equal to the CYCLE value of the clearing edge -> irq stays 1 (set wins).
- With DMEM_MISALIGN_CHECK_EN: write 32'h1111_1111 to 0x0000_0022 -> RAM word 8 unchanged, STATUS reads 32'h2. Without the macro: word 8 = 32'h1111_1111, STATUS bit1 = 0.
- Assert rst while writing 32'hFF to GPIO_OUT and with CYCLE=500 -> next cycle gpio_out=0, CYCLE reads 0, STATUS=0.
